// File: rtl/spi_pkg.sv
// Shared SPI link definitions: receiver FSM encodings and the default word
// length used by both the receive and transmit sides of the link.
package spi_pkg;

    // Receiver FSM encodings
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RECV = 2'b01;

    // Default bits per SPI word, shared with the transmit-side logic
    localparam int SPI_DATA_LENGTH = 8;

    // Bit counter width for a given word length; one spare bit so the
    // counter can hold DATA_LENGTH itself without wrapping
    function automatic int cnt_width(input int data_length);
        return $clog2(data_length) + 1;
    endfunction

endpackage

// File: rtl/spi_sck_edge.sv
// SPI input conditioning: optional 2-flop synchronizers on ss/sck/rx
// (enabled by defining SPI_RX_SYNC_EN) followed by an sck rising-edge
// detector. Without the macro the inputs are assumed clk-synchronous.
module spi_sck_edge (
    input  logic clk,
    input  logic prst,
    input  logic ss,
    input  logic sck,
    input  logic rx,
    output logic sck_rise,
    output logic ss_s,
    output logic rx_s
);

    logic sck_s;
    logic sck_q;

`ifdef SPI_RX_SYNC_EN
    logic [1:0] ss_sync;
    logic [1:0] sck_sync;
    logic [1:0] rx_sync;

    // Two-stage synchronizers; ss resets to its inactive (high) level
    always_ff @(posedge clk or posedge prst) begin
        if (prst) begin
            ss_sync  <= 2'b11;
            sck_sync <= 2'b00;
            rx_sync  <= 2'b00;
        end else begin
            ss_sync  <= {ss_sync[0], ss};
            sck_sync <= {sck_sync[0], sck};
            rx_sync  <= {rx_sync[0], rx};
        end
    end

    assign ss_s  = ss_sync[1];
    assign sck_s = sck_sync[1];
    assign rx_s  = rx_sync[1];
`else
    assign ss_s  = ss;
    assign sck_s = sck;
    assign rx_s  = rx;
`endif

    // Previous sck level for rising-edge detection
    always_ff @(posedge clk or posedge prst) begin
        if (prst) begin
            sck_q <= 1'b0;
        end else begin
            sck_q <= sck_s;
        end
    end

    assign sck_rise = sck_s & ~sck_q;

endmodule

// File: rtl/spi_rx.sv
// SPI slave receiver (mode 0, MSB first). Assembles DATA_LENGTH-bit words
// from MOSI and offers them downstream with a valid/ack handshake; flags
// overrun and truncated frames. Define SPI_RX_SYNC_EN to synchronize the
// SPI pins into clk (adds 2 clk of latency).
//
// Handshake: valid rises when a word is stored in data and stays high, with
// data stable, until a cycle with valid&ack. That cycle transfers the word;
// valid drops on the next edge unless a new word completes in the same
// cycle, in which case data is replaced and valid stays high. A word that
// completes while valid is high and ack is low is dropped and ovr pulses.
module spi_rx
    import spi_pkg::*;
#(
    parameter int DATA_LENGTH = SPI_DATA_LENGTH
) (
    input  logic                   clk,
    input  logic                   prst,
    input  logic                   ss,
    input  logic                   sck,
    input  logic                   rx,
    output logic [DATA_LENGTH-1:0] data,
    output logic                   valid,
    input  logic                   ack,
    output logic                   ovr,
    output logic                   frame_err,
    output logic [1:0]             fsm_state
);

    localparam int CW = cnt_width(DATA_LENGTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_LENGTH - 1);

    logic                   sck_rise;
    logic                   ss_s;
    logic                   rx_s;
    logic [1:0]             state;
    logic [DATA_LENGTH-1:0] sh;
    logic [CW-1:0]          cnt;
    logic                   sample;
    logic                   word_done;
    logic                   frame_abort;
    logic [DATA_LENGTH-1:0] shifted;

    spi_sck_edge u_edge (
        .clk      (clk),
        .prst     (prst),
        .ss       (ss),
        .sck      (sck),
        .rx       (rx),
        .sck_rise (sck_rise),
        .ss_s     (ss_s),
        .rx_s     (rx_s)
    );

    assign sample      = sck_rise & ~ss_s;
    assign shifted     = {sh[DATA_LENGTH-2:0], rx_s};
    assign word_done   = (state == RECV) && sample && (cnt == LAST_BIT);
    assign frame_abort = (state == RECV) && ss_s;
    assign fsm_state   = state;

    // Receive FSM: shift register and bit counter
    always_ff @(posedge clk or posedge prst) begin
        if (prst) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample) begin
                        sh    <= shifted;
                        cnt   <= CW'(1);
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (ss_s) begin
                        // Truncated frame: discard the partial word
                        sh    <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (sample) begin
                        sh <= shifted;
                        if (cnt == LAST_BIT) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output register, handshake and single-cycle error flags
    always_ff @(posedge clk or posedge prst) begin
        if (prst) begin
            data      <= '0;
            valid     <= 1'b0;
            ovr       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ovr       <= 1'b0;
            frame_err <= frame_abort;
            if (word_done) begin
                if (!valid || ack) begin
                    data  <= shifted;
                    valid <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end else if (valid && ack) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_rx.sv
// Testbench for spi_rx: directed SPI frames, expected words queued at
// stimulus time and checked by a negedge monitor when the DUT presents them.
module tb_spi_rx;
    import spi_pkg::*;

    localparam int W = 8;
`ifdef SPI_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic         clk;
    logic         prst;
    logic         ss;
    logic         sck;
    logic         rx;
    logic [W-1:0] data;
    logic         valid;
    logic         ack;
    logic         ovr;
    logic         frame_err;
    logic [1:0]   fsm_state;

    int           checks;
    int           failures;
    logic [W-1:0] exp_q[$];
    int           ovr_cnt;
    int           ferr_cnt;
    int           word_cnt;
    bit           auto_ack;
    int           lat;

    logic         valid_q;
    logic         acc_q;
    logic         ovr_q;
    logic         ferr_q;

    spi_rx #(.DATA_LENGTH(W)) dut (
        .clk       (clk),
        .prst      (prst),
        .ss        (ss),
        .sck       (sck),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ack       (ack),
        .ovr       (ovr),
        .frame_err (frame_err),
        .fsm_state (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Advance n clocks; inputs change 1 time unit after the rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (auto_ack) ack = valid & ~ack;
        end
    endtask

    // One SPI bit: 4 clk low with rx set up, 4 clk high
    task automatic send_bit(input logic b, input bit measure, input bit ack_last);
        rx = b;
        tick(4);
        sck = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (ack_last && k == SYNC_LAT) ack = 1'b1;
            tick(1);
            if (ack_last && k == SYNC_LAT) ack = 1'b0;
            if (measure && lat < 0 && valid === 1'b1) lat = k + 1;
        end
        sck = 1'b0;
    endtask

    // Top n bits of w, MSB first; measure/ack_last apply to the final bit
    task automatic send_bits(input logic [W-1:0] w, input int n, input bit measure, input bit ack_last);
        for (int i = W - 1; i >= W - n; i--) begin
            send_bit(w[i], measure && (i == W - n), ack_last && (i == W - n));
        end
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit measure, input bit ack_last);
        ss = 1'b0;
        tick(2);
        send_bits(w, W, measure, ack_last);
        tick(2);
        ss = 1'b1;
        tick(2);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ovr_cnt  = 0;
        ferr_cnt = 0;
        word_cnt = 0;
        auto_ack = 1'b0;
        lat      = -1;
        prst     = 1'b1;
        ss       = 1'b1;
        sck      = 1'b0;
        rx       = 1'b0;
        ack      = 1'b0;
        valid_q  = 1'b0;
        acc_q    = 1'b0;
        ovr_q    = 1'b0;
        ferr_q   = 1'b0;

        fork
            // Monitor: pop and compare whenever a new word is presented
            forever begin
                @(negedge clk);
                if (prst) begin
                    valid_q = 1'b0;
                    acc_q   = 1'b0;
                    ovr_q   = 1'b0;
                    ferr_q  = 1'b0;
                end else begin
                    if (valid === 1'b1 && (!valid_q || acc_q)) begin
                        word_cnt++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL word: got %0h expected none", data);
                        end else begin
                            check("word", data, exp_q.pop_front());
                        end
                    end
                    if (ovr === 1'b1) begin
                        check("ovr_width", ovr_q, 0);
                        if (!ovr_q) ovr_cnt++;
                    end
                    if (frame_err === 1'b1) begin
                        check("ferr_width", ferr_q, 0);
                        if (!ferr_q) ferr_cnt++;
                    end
                    valid_q = valid;
                    acc_q   = valid & ack;
                    ovr_q   = ovr;
                    ferr_q  = frame_err;
                end
            end

            // Stimulus
            begin
                tick(2);
                check("rst_data", data, 0);
                check("rst_valid", valid, 0);
                check("rst_ovr", ovr, 0);
                check("rst_ferr", frame_err, 0);
                check("rst_state", fsm_state, IDLE);
                prst = 1'b0;
                tick(2);

                // 1: A5 with no ack, measure completion latency
                exp_q.push_back(8'hA5);
                send_frame(8'hA5, 1'b1, 1'b0);
                tick(4);
                check("t1_valid", valid, 1);
                check("t1_data", data, 8'hA5);
                check("t1_ovr_cnt", ovr_cnt, 0);
                check("t1_latency", lat, 1 + SYNC_LAT);
                check("t1_drained", exp_q.size(), 0);

                // 2: 3C while A5 pending and unacked -> overrun, A5 kept
                send_frame(8'h3C, 1'b0, 1'b0);
                tick(4);
                check("t2_ovr_cnt", ovr_cnt, 1);
                check("t2_data", data, 8'hA5);
                check("t2_valid", valid, 1);
                ack_pulse();
                check("t2_valid_after_ack", valid, 0);

                // 3: ack in the completion cycle of 3C replaces A5, no overrun
                exp_q.push_back(8'hA5);
                send_frame(8'hA5, 1'b0, 1'b0);
                tick(4);
                exp_q.push_back(8'h3C);
                send_frame(8'h3C, 1'b0, 1'b1);
                tick(4);
                check("t3_data", data, 8'h3C);
                check("t3_valid", valid, 1);
                check("t3_ovr_cnt", ovr_cnt, 1);
                check("t3_drained", exp_q.size(), 0);
                ack_pulse();
                check("t3_valid_after_ack", valid, 0);

                // 4: 3-bit truncated frame, then 81 intact
                ss = 1'b0;
                tick(2);
                send_bits(8'hA0, 3, 1'b0, 1'b0);
                tick(2);
                ss = 1'b1;
                tick(4);
                check("t4_ferr_cnt", ferr_cnt, 1);
                check("t4_valid", valid, 0);
                check("t4_state", fsm_state, IDLE);
                exp_q.push_back(8'h81);
                send_frame(8'h81, 1'b0, 1'b0);
                tick(4);
                check("t4_data", data, 8'h81);
                check("t4_valid2", valid, 1);
                check("t4_ferr_cnt2", ferr_cnt, 1);

                // 5: async reset mid-frame with 81 still pending
                ss = 1'b0;
                tick(2);
                send_bits(8'hF8, 5, 1'b0, 1'b0);
                tick(1);
                #2;
                prst = 1'b1;
                #1;
                check("t5_data", data, 0);
                check("t5_valid", valid, 0);
                check("t5_ovr", ovr, 0);
                check("t5_ferr", frame_err, 0);
                check("t5_state", fsm_state, IDLE);
                ss = 1'b1;
                tick(2);
                prst = 1'b0;
                tick(2);
                exp_q.push_back(8'hFF);
                send_frame(8'hFF, 1'b0, 1'b0);
                tick(4);
                check("t5_data_ff", data, 8'hFF);
                check("t5_ferr_cnt", ferr_cnt, 1);
                ack_pulse();

                // 6: back-to-back 12, 34 with ss held low, acked as presented
                word_cnt = 0;
                auto_ack = 1'b1;
                exp_q.push_back(8'h12);
                exp_q.push_back(8'h34);
                ss = 1'b0;
                tick(2);
                send_bits(8'h12, W, 1'b0, 1'b0);
                send_bits(8'h34, W, 1'b0, 1'b0);
                tick(2);
                ss = 1'b1;
                tick(6);
                auto_ack = 1'b0;
                ack = 1'b0;
                check("t6_words", word_cnt, 2);
                check("t6_drained", exp_q.size(), 0);
                check("t6_valid", valid, 0);
                check("t6_ovr_cnt", ovr_cnt, 1);
                check("t6_ferr_cnt", ferr_cnt, 1);
                check("t6_last_data", data, 8'h34);

                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end

            // Watchdog
            begin
                #200000;
                checks++;
                failures++;
                $display("FAIL watchdog: got timeout expected completion");
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        join
    end

endmodule
